// File: rtl/hazard_unit_p_if.sv
// rtl/hazard_unit_p_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_unit_p_if #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
);
  // decode stage
  logic [REG_ADDR_W-1:0] rs_fd;
  logic [REG_ADDR_W-1:0] rt_fd;
  logic                  rs_used_fd;
  logic                  rt_used_fd;
  logic                  is_branch_fd;
  logic                  branch_taken;
  // ID-EX
  logic [REG_ADDR_W-1:0] rs_dx;
  logic [REG_ADDR_W-1:0] rt_dx;
  logic [REG_ADDR_W-1:0] rd_dx;
  logic                  regwrite_dx;
  logic                  memread_dx;
  logic                  alusrc_dx;
  // EX-MEM
  logic [REG_ADDR_W-1:0] rd_xm;
  logic                  regwrite_xm;
  logic                  memread_xm;
  // MEM-WB
  logic [REG_ADDR_W-1:0] rd_mw;
  logic                  regwrite_mw;
  // hazard unit responses
  logic                  stall;
  logic                  bubble;
  logic                  flush_fd;
  logic [1:0]            frwrd_alu1;
  logic [1:0]            frwrd_alu2;
  logic [2:0]            frwrd_branch;
  logic [CNT_W-1:0]      perf_stall_cycles;
  logic [CNT_W-1:0]      perf_flushes;

  // pipeline side
  modport master (
    output rs_fd, rt_fd, rs_used_fd, rt_used_fd, is_branch_fd, branch_taken,
    output rs_dx, rt_dx, rd_dx, regwrite_dx, memread_dx, alusrc_dx,
    output rd_xm, regwrite_xm, memread_xm, rd_mw, regwrite_mw,
    input  stall, bubble, flush_fd, frwrd_alu1, frwrd_alu2, frwrd_branch,
    input  perf_stall_cycles, perf_flushes
  );

  // hazard unit side
  modport slave (
    input  rs_fd, rt_fd, rs_used_fd, rt_used_fd, is_branch_fd, branch_taken,
    input  rs_dx, rt_dx, rd_dx, regwrite_dx, memread_dx, alusrc_dx,
    input  rd_xm, regwrite_xm, memread_xm, rd_mw, regwrite_mw,
    output stall, bubble, flush_fd, frwrd_alu1, frwrd_alu2, frwrd_branch,
    output perf_stall_cycles, perf_flushes
  );
endinterface

// File: rtl/hazard_unit_p.sv
// rtl/hazard_unit_p.sv - forwarding selects, load hazard stall sequencer, optional perf counters (HAZARD_PERF_CNT_EN)
module hazard_unit_p #(
  parameter int REG_ADDR_W    = 3,
  parameter int R0_HARDWIRED  = 1,
  parameter int BR_LOAD_STALL = 2,   // legal range 1..7 (3-bit hold counter)
  parameter int CNT_W         = 16
) (
  input  logic           clk,
  input  logic           rst,        // asynchronous, active low
  hazard_unit_p_if.slave hz
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Cycles spent in HOLD after the detection cycle of a load-to-branch hazard.
  localparam logic [2:0] HOLD_LEN = 3'(BR_LOAD_STALL - 1);
  localparam bit         LONG_BLD = (BR_LOAD_STALL > 1);

  // A destination feeds a source only if the specifiers agree and the source
  // is not the hardwired zero register.
  function automatic logic srcMatch(input logic [REG_ADDR_W-1:0] dst,
                                    input logic [REG_ADDR_W-1:0] src);
    return (dst == src) && !((R0_HARDWIRED != 0) && (src == '0));
  endfunction

  logic [1:0] frwrdAlu1;
  logic [1:0] frwrdAlu2;
  logic [2:0] frwrdBranch;

  // EX operand A: youngest producer (XM) wins over MW.
  always_comb begin
    frwrdAlu1 = 2'd0;
    if (hz.regwrite_xm && srcMatch(hz.rd_xm, hz.rs_dx)) begin
      frwrdAlu1 = 2'd2;
    end else if (hz.regwrite_mw && srcMatch(hz.rd_mw, hz.rs_dx)) begin
      frwrdAlu1 = 2'd1;
    end
  end

  // EX operand B: immediate operands never forward.
  always_comb begin
    frwrdAlu2 = 2'd0;
    if (!hz.alusrc_dx) begin
      if (hz.regwrite_xm && srcMatch(hz.rd_xm, hz.rt_dx)) begin
        frwrdAlu2 = 2'd2;
      end else if (hz.regwrite_mw && srcMatch(hz.rd_mw, hz.rt_dx)) begin
        frwrdAlu2 = 2'd1;
      end
    end
  end

  // Decode-branch operand: a load in XM has no data yet, so it is skipped here
  // and covered by the stall sequencer instead.
  always_comb begin
    frwrdBranch = 3'd0;
    if (hz.regwrite_xm && !hz.memread_xm && srcMatch(hz.rd_xm, hz.rs_fd)) begin
      frwrdBranch = 3'd2;
    end else if (hz.regwrite_mw && srcMatch(hz.rd_mw, hz.rs_fd)) begin
      frwrdBranch = 3'd1;
    end else if (hz.regwrite_dx && !hz.memread_dx && srcMatch(hz.rd_dx, hz.rs_fd)) begin
      frwrdBranch = 3'd4;
    end
  end

  assign hz.frwrd_alu1   = frwrdAlu1;
  assign hz.frwrd_alu2   = frwrdAlu2;
  assign hz.frwrd_branch = frwrdBranch;

  logic dxLoad;
  logic xmLoad;
  logic luHaz;
  logic bldHaz;
  logic blxHaz;
  logic anyHaz;

  assign dxLoad = hz.memread_dx && hz.regwrite_dx;
  assign xmLoad = hz.memread_xm && hz.regwrite_xm;
  assign luHaz  = dxLoad && ((hz.rs_used_fd && srcMatch(hz.rd_dx, hz.rs_fd)) ||
                             (hz.rt_used_fd && srcMatch(hz.rd_dx, hz.rt_fd)));
  assign bldHaz = hz.is_branch_fd && dxLoad && srcMatch(hz.rd_dx, hz.rs_fd);
  assign blxHaz = hz.is_branch_fd && xmLoad && srcMatch(hz.rd_xm, hz.rs_fd);
  assign anyHaz = luHaz || bldHaz || blxHaz;

  state_t     state;
  state_t     stateNext;
  logic [2:0] cnt;
  logic [2:0] cntNext;
  logic       stallRaw;
  logic       flushRaw;
  logic       stallOut;
  logic       flushOut;

  // Sequencer state and remaining-hold counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Only the load-to-branch-in-DX case needs more than one stall cycle, so it
  // is the only detection that enters HOLD; single-cycle stalls stay in IDLE.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stallRaw  = 1'b0;
    case (state)
      IDLE: begin
        stallRaw = anyHaz;
        if (bldHaz && LONG_BLD) begin
          stateNext = HOLD;
          cntNext   = HOLD_LEN;
        end
      end
      HOLD: begin
        stallRaw = 1'b1;
        cntNext  = cnt - 3'd1;
        if (cnt == 3'd1) begin
          stateNext = IDLE;
          cntNext   = 3'd0;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = 3'd0;
      end
    endcase
  end

  // A redirect resolved while stalling used stale operands and is dropped.
  assign flushRaw = hz.branch_taken && !stallRaw;

  assign stallOut    = rst && stallRaw;
  assign flushOut    = rst && flushRaw;
  assign hz.stall    = stallOut;
  assign hz.bubble   = stallOut;
  assign hz.flush_fd = flushOut;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perfStall;
  logic [CNT_W-1:0] perfFlush;

  // Saturating event counters; inside the non-reset branch stallRaw equals stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfStall <= '0;
      perfFlush <= '0;
    end else begin
      if (stallRaw && (perfStall != '1)) begin
        perfStall <= perfStall + CNT_W'(1);
      end
      if (flushRaw && (perfFlush != '1)) begin
        perfFlush <= perfFlush + CNT_W'(1);
      end
    end
  end

  assign hz.perf_stall_cycles = perfStall;
  assign hz.perf_flushes      = perfFlush;
`else
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  assign hz.perf_stall_cycles = CNT_ZERO;
  assign hz.perf_flushes      = CNT_ZERO;
`endif

endmodule
